exp2_pwl_pipe: RTL

- Pipelined, parametrised 2^x unit for x ≤ 0, aimed at the softmax datapath. It consumes the (x − max) values that feed the exponent stage.
- Splits x into an integer part and a fraction. The fraction is approximated with a piecewise-linear table of 2^SEG_LOG2 chords, and the integer part is applied as a right shift.
- Streams one sample per cycle with a valid/ready handshake on both sides. A sideband tag travels alongside each sample for channel/index tracking.

---
 rtl/exp2_pwl_pipe.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/exp2_pwl_pipe.sv
// exp2_pwl_pipe -- pipelined 2^x for x <= 0, feeding the softmax exponent stage.
//
// x (S2.F, F = D_W-3) is split into n = floor(x) and a fraction r. 2^r is taken
// from a piecewise-linear chord table with 2^SEG_LOG2 segments, and 2^n is then
// applied as a right shift of -n. Inputs with x > 0 are flagged on O_ERR and
// return 1.0.
//
// Pipeline: decompose -> multiply -> add/shift. The latency is 3 cycles.
// All stages share one enable, en = ~O_VALID | I_READY, so the whole pipe
// freezes while the output is held.
//
// Optional build macro:
//   EXP2_PWL_ROUND_EN : round-half-up at the p>>F and final-shift truncation
//                       points, with the result clamped to 2^(F+1)-1.
//                       When undefined, both points truncate.
//
// Ports:
//   I_CLK, I_RST      clock; synchronous active-high reset
//   I_VALID, O_READY  input handshake
//   I_X, I_TAG        signed x (S2.F) and its sideband tag
//   O_VALID, I_READY  output handshake
//   O_Y, O_TAG        2^x (unsigned, S2.F, 1.0 = 2^F) and its tag
//   O_ERR             the input was out of domain (x > 0)
module exp2_pwl_pipe #(
    parameter int D_W      = 16,
    parameter int SEG_LOG2 = 3,
    parameter int TAG_W    = 4
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic             I_VALID,
    output logic             O_READY,
    input  logic [D_W-1:0]   I_X,
    input  logic [TAG_W-1:0] I_TAG,
    output logic             O_VALID,
    input  logic             I_READY,
    output logic [D_W-1:0]   O_Y,
    output logic [TAG_W-1:0] O_TAG,
    output logic             O_ERR
);

    localparam int F      = D_W - 3;
    localparam int N      = 1 << SEG_LOG2;
    localparam int C_W    = F + 2;          // coefficient width
    localparam int D_BITS = F - SEG_LOG2;   // bits of the in-segment offset d
    localparam int P_W    = C_W + D_BITS;   // full product width

    // Table generation runs in Q30 integer arithmetic. 2^(1/N) is obtained by
    // taking the square root of 2 SEG_LOG2 times, because N is a power of two.
    // This keeps the constant functions free of real-valued math.
    function automatic longint unsigned isqrt_q(input longint unsigned v);
        longint unsigned lo, hi, mid;
        lo = 64'd0;
        hi = 64'h1_0000_0000;
        while (hi - lo > 64'd1) begin
            mid = (lo + hi) >> 1;
            if (mid * mid <= v) lo = mid;
            else                hi = mid;
        end
        return lo;
    endfunction

    function automatic longint unsigned pow2_q30(input int k);
        longint unsigned root, p;
        root = 64'd1 << 31;
        for (int i = 0; i < SEG_LOG2; i++) root = isqrt_q(root << 30);
        p = 64'd1 << 30;
        for (int i = 0; i < k; i++) p = (p * root + (64'd1 << 29)) >> 30;
        return p;
    endfunction

    function automatic logic [C_W-1:0] coef_a(input int k);
        return C_W'((pow2_q30(k) + (64'd1 << (29 - F))) >> (30 - F));
    endfunction

    function automatic logic [C_W-1:0] coef_b(input int k);
        longint unsigned diff;
        diff = (pow2_q30(k + 1) - pow2_q30(k)) * 64'(N);
        return C_W'((diff + (64'd1 << (29 - F))) >> (30 - F));
    endfunction

    logic [C_W-1:0] a_tab [N];
    logic [C_W-1:0] b_tab [N];

    for (genvar g = 0; g < N; g++) begin : g_tab
        localparam logic [C_W-1:0] A_K = coef_a(g);
        localparam logic [C_W-1:0] B_K = coef_b(g);
        assign a_tab[g] = A_K;
        assign b_tab[g] = B_K;
    end

    logic en;
    assign en      = ~O_VALID | I_READY;
    assign O_READY = en;

    // Stage 1: decompose. sh = -n is in 0..4, and 3 bits hold it unsigned.
    logic          x_err;
    logic [2:0]    x_int;
    logic [2:0]    x_sh;
    logic [F-1:0]  x_r;

    always_comb begin
        x_err = ~I_X[D_W-1] & (|I_X[D_W-2:0]);
        x_int = I_X[D_W-1:F];
        x_sh  = x_err ? 3'd0 : 3'd0 - x_int;
        x_r   = x_err ? '0 : I_X[F-1:0];
    end

    logic                s1_valid, s2_valid;
    logic [SEG_LOG2-1:0] s1_k;
    logic [D_BITS-1:0]   s1_d;
    logic [2:0]          s1_sh, s2_sh;
    logic                s1_err, s2_err;
    logic [TAG_W-1:0]    s1_tag, s2_tag;
    logic [C_W-1:0]      s2_a;
    logic [P_W-1:0]      s2_p;

    // Stage 3: add and shift
    logic [C_W-1:0] y_c;

`ifdef EXP2_PWL_ROUND_EN
    localparam logic [C_W-1:0] Y_MAX = C_W'((64'd1 << (F + 1)) - 64'd1);
    logic [P_W-1:0] p_half;
    logic [C_W:0]   m_sum;
    logic [C_W:0]   round_add;
    logic [C_W:0]   y_full;

    always_comb begin
        p_half    = P_W'(64'd1 << (F - 1));
        m_sum     = {1'b0, s2_a} + (C_W+1)'((s2_p + p_half) >> F);
        round_add = (s2_sh == 3'd0) ? '0 : (C_W+1)'(1) << (s2_sh - 3'd1);
        y_full    = (m_sum + round_add) >> s2_sh;
        y_c       = (|y_full[C_W:F+1]) ? Y_MAX : y_full[C_W-1:0];
    end
`else
    logic [C_W-1:0] m_sum;

    always_comb begin
        m_sum = s2_a + C_W'(s2_p >> F);
        y_c   = m_sum >> s2_sh;
    end
`endif

    // Valids and output registers; reset drops everything in flight.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            O_VALID  <= 1'b0;
            O_Y      <= '0;
            O_TAG    <= '0;
            O_ERR    <= 1'b0;
        end else if (en) begin
            s1_valid <= I_VALID;
            s2_valid <= s1_valid;
            O_VALID  <= s2_valid;
            O_Y      <= {1'b0, y_c};
            O_TAG    <= s2_tag;
            O_ERR    <= s2_err;
        end
    end

    // Datapath registers are qualified by the valids, so they need no reset.
    always_ff @(posedge I_CLK) begin
        if (en) begin
            s1_k   <= x_r[F-1:F-SEG_LOG2];
            s1_d   <= x_r[D_BITS-1:0];
            s1_sh  <= x_sh;
            s1_err <= x_err;
            s1_tag <= I_TAG;
            s2_a   <= a_tab[s1_k];
            s2_p   <= P_W'(b_tab[s1_k]) * P_W'(s1_d);
            s2_sh  <= s1_sh;
            s2_err <= s1_err;
            s2_tag <= s1_tag;
        end
    end

endmodule
